// File: rtl/condicionador_entradas_if.sv
// Bus between the raw panel inputs and the conditioned levels/strobes seen by maq1 and maq2.
// The master drives the raw levels; the conditioner (slave) drives the clean outputs.
interface condicionador_entradas_if #(
  parameter int N_CH = 7
);
  logic [N_CH-1:0] entrada_bruta;
  logic [N_CH-1:0] saida_estavel;
  logic [N_CH-1:0] pulso_subida;
  logic [N_CH-1:0] pulso_descida;
  logic            mudou;

  modport master (
    output entrada_bruta,
    input  saida_estavel,
    input  pulso_subida,
    input  pulso_descida,
    input  mudou
  );

  modport slave (
    input  entrada_bruta,
    output saida_estavel,
    output pulso_subida,
    output pulso_descida,
    output mudou
  );
endinterface

// File: rtl/condicionador_entradas.sv
// Input conditioner: 2-flop synchroniser plus per-channel debounce with rise/fall strobes.
// Channel order {sr, sn, sp, b1, b0, v1, v0}; every output is registered.
module condicionador_entradas #(
  parameter int N_CH    = 7,
  parameter int DEB_LEN = 4,
  parameter int CNT_W   = 3
) (
  input logic clk,
  input logic rst,
  condicionador_entradas_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_LEN - 1);

  logic [N_CH-1:0]  sync1;
  logic [N_CH-1:0]  sync2;
  logic [N_CH-1:0]  estavel;
  logic [N_CH-1:0]  subida;
  logic [N_CH-1:0]  descida;
  logic             mudou_q;
  logic [CNT_W-1:0] cnt [N_CH];

  logic [N_CH-1:0]  estavel_n;
  logic [N_CH-1:0]  subida_n;
  logic [N_CH-1:0]  descida_n;
  logic [CNT_W-1:0] cnt_n [N_CH];

  // Any return of sync2 to the stable level discards a partial count.
  always_comb begin
    estavel_n = estavel;
    subida_n  = '0;
    descida_n = '0;
    for (int i = 0; i < N_CH; i++) begin
      cnt_n[i] = '0;
      if (sync2[i] != estavel[i]) begin
        if (cnt[i] == CNT_MAX) begin
          estavel_n[i] = sync2[i];
          subida_n[i]  = sync2[i];
          descida_n[i] = ~sync2[i];
        end else begin
          cnt_n[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      estavel <= '0;
      subida  <= '0;
      descida <= '0;
      mudou_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= bus.entrada_bruta;
      sync2   <= sync1;
      estavel <= estavel_n;
      subida  <= subida_n;
      descida <= descida_n;
      mudou_q <= |(subida_n | descida_n);
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_n[i];
      end
    end
  end

  assign bus.saida_estavel = estavel;
  assign bus.pulso_subida  = subida;
  assign bus.pulso_descida = descida;
  assign bus.mudou         = mudou_q;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Scoreboard bench for condicionador_entradas: a window-based reference model pushes expected
// outputs per edge, a monitor pops and compares them on the falling edge.
module tb_condicionador_entradas;

  localparam int N_CH    = 7;
  localparam int DEB_LEN = 4;
  localparam int CNT_W   = 3;

  typedef struct packed {
    logic [N_CH-1:0] st;
    logic [N_CH-1:0] su;
    logic [N_CH-1:0] de;
    logic            mu;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  condicionador_entradas_if #(.N_CH(N_CH)) bus ();

  condicionador_entradas #(
    .N_CH   (N_CH),
    .DEB_LEN(DEB_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t            expq [$];
  logic [N_CH-1:0] hist [$];
  logic [N_CH-1:0] m_stable;

  task automatic checkOutput(input string name, input exp_t e);
    total++;
    if (bus.saida_estavel !== e.st) begin
      bad++;
      $display("[TB] FAIL %s saida_estavel got=%h want=%h t=%0t", name, bus.saida_estavel, e.st, $time);
    end
    total++;
    if (bus.pulso_subida !== e.su) begin
      bad++;
      $display("[TB] FAIL %s pulso_subida got=%h want=%h t=%0t", name, bus.pulso_subida, e.su, $time);
    end
    total++;
    if (bus.pulso_descida !== e.de) begin
      bad++;
      $display("[TB] FAIL %s pulso_descida got=%h want=%h t=%0t", name, bus.pulso_descida, e.de, $time);
    end
    total++;
    if (bus.mudou !== e.mu) begin
      bad++;
      $display("[TB] FAIL %s mudou got=%b want=%b t=%0t", name, bus.mudou, e.mu, $time);
    end
  endtask

  // Reference model: a channel accepts a new level once the last DEB_LEN synchronised
  // samples (raw samples delayed by two edges) all disagree with its current stable level.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        expq.delete();
        hist.delete();
        for (int j = 0; j < DEB_LEN + 2; j++) hist.push_back('0);
        m_stable = '0;
      end else begin
        exp_t e;
        e = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
          bit all_differ;
          all_differ = 1'b1;
          for (int w = 0; w < DEB_LEN; w++) begin
            if (hist[hist.size() - 2 - w][ch] == m_stable[ch]) all_differ = 1'b0;
          end
          if (all_differ) begin
            m_stable[ch] = ~m_stable[ch];
            e.su[ch] = m_stable[ch];
            e.de[ch] = ~m_stable[ch];
          end
        end
        e.st = m_stable;
        e.mu = |(e.su | e.de);
        expq.push_back(e);
        hist.push_back(bus.entrada_bruta);
        if (hist.size() > DEB_LEN + 2) void'(hist.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && expq.size() > 0) checkOutput("scoreboard", expq.pop_front());
    end
  end

  task automatic applyStimulus(input logic [N_CH-1:0] v, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.entrada_bruta = v;
    end
  endtask

  initial begin
    logic [N_CH-1:0] cur;
    logic            bounce [8];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.entrada_bruta = 7'h7F;
    repeat (3) @(posedge clk);
    #1 checkOutput("reset_hold", '0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(7'h7F, 10);

    applyStimulus(7'h00, 10);
    applyStimulus(7'h20, 10);

    applyStimulus(7'h30, 3);
    applyStimulus(7'h20, 10);

    bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) applyStimulus(bounce[k] ? 7'h28 : 7'h20, 1);
    applyStimulus(7'h28, 10);

    applyStimulus(7'h2B, 10);
    applyStimulus(7'h28, 10);

    cur = 7'h28;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) cur = cur ^ (7'h01 << $urandom_range(0, N_CH - 1));
      applyStimulus(cur, 1);
    end

    applyStimulus(7'h7F, 12);
    applyStimulus(7'h00, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", '0);
    #4 rst = 1'b0;
    applyStimulus(7'h00, 3);
    applyStimulus(7'h55, 12);
    applyStimulus(7'h00, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
